// File: rtl/adc_sample_averager.sv
// Per-channel boxcar averager that drains the ADC sample FIFO one entry at a time
// and flags completed averages that fall outside the hi/lo window.
module adc_sample_averager #(
  parameter int CH_NUM   = 8,
  parameter int DW       = 10,
  parameter int CHW      = 4,
  parameter int MAX_LOG2 = 7
) (
  input  logic              pclk,
  input  logic              rstb,
  input  logic              enable,
  input  logic              clear,
  input  logic [2:0]        avg_log2,
  input  logic [CH_NUM-1:0] ch_mask,
  input  logic [DW-1:0]     thr_hi,
  input  logic [DW-1:0]     thr_lo,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              fifo_valid,
  input  logic [CHW+DW-1:0] fifo_dout,
  input  logic [CHW-1:0]    res_sel,
  output logic [DW-1:0]     res_data,
  output logic [CH_NUM-1:0] res_valid,
  output logic              done_pulse,
  output logic [CH_NUM-1:0] win_flag,
  output logic [1:0]        err_flag
);

  localparam int AW   = DW + MAX_LOG2;
  localparam int CNTW = MAX_LOG2 + 1;
  localparam int CIW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ACC  = 2'd3;

  logic [1:0]     state;
  logic [1:0]     wait_cnt;
  logic           enable_d;
  logic [2:0]     lat_l;
  logic [2:0]     avg_clip;
  logic [CHW-1:0] ent_chan;
  logic [DW-1:0]  ent_sample;

  logic [AW-1:0]   acc    [CH_NUM];
  logic [CNTW-1:0] cnt    [CH_NUM];
  logic [DW-1:0]   result [CH_NUM];

  logic [CIW-1:0]  ci;
  logic            chan_bad;
  logic            timeout;
  logic [AW-1:0]   acc_sum;
  logic [CNTW-1:0] cnt_inc;
  logic [CNTW-1:0] cnt_target;
  logic            win_done;
  logic [DW-1:0]   new_res;

  assign avg_clip   = (int'(avg_log2) > MAX_LOG2) ? 3'(MAX_LOG2) : avg_log2;
  assign fifo_rd_en = (state == S_POP);
  assign timeout    = (state == S_WAIT) && !fifo_valid && (wait_cnt == 2'd3);

  assign ci         = ent_chan[CIW-1:0];
  assign chan_bad   = (int'(ent_chan) >= CH_NUM);
  assign acc_sum    = acc[ci] + AW'(ent_sample);
  assign cnt_inc    = cnt[ci] + CNTW'(1);
  assign cnt_target = CNTW'(1) << lat_l;
  // >= rather than == so a window shortened by a new L still closes
  assign win_done   = (cnt_inc >= cnt_target);
  assign new_res    = DW'(acc_sum >> lat_l);

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      enable_d   <= 1'b0;
      lat_l      <= '0;
      ent_chan   <= '0;
      ent_sample <= '0;
    end else begin
      enable_d <= enable;
      if (enable && !enable_d)
        lat_l <= avg_clip;
      case (state)
        S_IDLE: if (enable && !fifo_empty) state <= S_POP;
        S_POP: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (fifo_valid) begin
            ent_chan   <= fifo_dout[CHW+DW-1:DW];
            ent_sample <= fifo_dout[DW-1:0];
            state      <= S_ACC;
          end else if (wait_cnt == 2'd3) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // clear has priority over everything, including the entry sitting in ACC
  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < CH_NUM; i++) begin
        acc[i]    <= '0;
        cnt[i]    <= '0;
        result[i] <= '0;
      end
      res_valid  <= '0;
      win_flag   <= '0;
      err_flag   <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (clear) begin
        for (int i = 0; i < CH_NUM; i++) begin
          acc[i]    <= '0;
          cnt[i]    <= '0;
          result[i] <= '0;
        end
        res_valid <= '0;
        win_flag  <= '0;
        err_flag  <= '0;
      end else begin
        if (timeout)
          err_flag[1] <= 1'b1;
        if (state == S_ACC) begin
          if (chan_bad) begin
            err_flag[0] <= 1'b1;
          end else if (ch_mask[ci]) begin
            if (win_done) begin
              result[ci]    <= new_res;
              acc[ci]       <= '0;
              cnt[ci]       <= '0;
              res_valid[ci] <= 1'b1;
              done_pulse    <= 1'b1;
              if ((new_res > thr_hi) || (new_res < thr_lo))
                win_flag[ci] <= 1'b1;
            end else begin
              acc[ci] <= acc_sum;
              cnt[ci] <= cnt_inc;
            end
          end
        end
      end
    end
  end

  always_comb begin
    res_data = '0;
    if (int'(res_sel) < CH_NUM)
      res_data = result[res_sel[CIW-1:0]];
  end

endmodule
